// File: rtl/spi_reg_bank_pkg.sv
// Shared constants and FSM encoding for the SPI configuration register bank.
package spi_reg_bank_pkg;
    localparam int NUM_REGS   = 9;
    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int CNT_W      = 5;
    localparam int CNT_SAT    = FRAME_BITS + 1;

    localparam logic [ADDR_W-1:0] ADDR_EN_OUT      = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM      = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_CH_3_0      = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_CH_7_4      = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_G0_C0_DUTY  = 7'h04;
    localparam logic [ADDR_W-1:0] ADDR_G0_C1_DUTY  = 7'h05;
    localparam logic [ADDR_W-1:0] ADDR_G1_C0_DUTY  = 7'h06;
    localparam logic [ADDR_W-1:0] ADDR_G1_C1_DUTY  = 7'h07;
    localparam logic [ADDR_W-1:0] ADDR_FREQ_DIV    = 7'h08;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RX     = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;
endpackage

// File: rtl/spi_reg_bank_sync_edge.sv
// Multi-flop synchronizer for an async pin with single-cycle rise/fall pulses.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise,
    output logic o_fall
);
    logic [STAGES-1:0] r_sync;
    logic              r_dly;
    logic              w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {STAGES{RST_VAL}};
            r_dly  <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_dly  <= r_sync[STAGES-1];
        end
    end

    assign w_last = r_sync[STAGES-1];
    assign o_rise = w_last & ~r_dly;
    assign o_fall = ~w_last & r_dly;
endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 target driving the PWM block's configuration registers.
module spi_reg_bank #(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = spi_reg_bank_pkg::NUM_REGS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic [7:0] reg_en_out,
    output logic [7:0] reg_en_pwm_out,
    output logic [7:0] reg_out_3_0_pwm_gen_channel,
    output logic [7:0] reg_out_7_4_pwm_gen_channel,
    output logic [7:0] reg_pwm_gen_0_ch_0_duty_cycle,
    output logic [7:0] reg_pwm_gen_0_ch_1_duty_cycle,
    output logic [7:0] reg_pwm_gen_1_ch_0_duty_cycle,
    output logic [7:0] reg_pwm_gen_1_ch_1_duty_cycle,
    output logic [7:0] reg_pwm_gen_1_0_frequency_divider
);
    import spi_reg_bank_pkg::*;

    localparam int SLOTS = 9;

    logic                   w_sclk_rise, w_sclk_fall, w_ncs_rise, w_ncs_fall;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic                   w_copi;

    state_t                 r_state, w_state_nxt;
    logic                   w_clear, w_commit;
    logic [CNT_W-1:0]       r_cnt;
    logic [FRAME_BITS-1:0]  r_shift, w_shift_nxt;
    logic [ADDR_W-1:0]      w_addr;
    logic [7:0]             r_out, w_rd_data;
    logic                   r_rd_act, r_pend, r_wr_strobe;
    logic [ADDR_W-1:0]      r_wr_addr;
    logic [7:0]             r_regs [SLOTS];

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(sclk),
        .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ncs (
        .clk(clk), .rst_n(rst_n), .i_async(ncs),
        .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_copi_sync <= '0;
        else        r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
    end
    assign w_copi = r_copi_sync[SYNC_STAGES-1];

    assign w_shift_nxt = {r_shift[FRAME_BITS-2:0], w_copi};
    assign w_addr      = r_shift[FRAME_BITS-2:8];

    // Read data is addressed by the first 8 bits as they complete.
    always_comb begin
        w_rd_data = 8'h00;
        for (int i = 0; i < SLOTS; i++)
            if (i < NUM_REGS && w_shift_nxt[ADDR_W-1:0] == ADDR_W'(i))
                w_rd_data = r_regs[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_ncs_fall || r_pend) begin
                    w_state_nxt = ST_RX;
                    w_clear     = 1'b1;
                end
            end
            ST_RX: begin
                if (w_ncs_rise)
                    w_state_nxt = (r_cnt == '0) ? ST_IDLE : ST_COMMIT;
            end
            ST_COMMIT: begin
                w_state_nxt = ST_IDLE;
                w_commit    = (r_cnt == CNT_W'(FRAME_BITS)) && r_shift[FRAME_BITS-1]
                              && (w_addr < ADDR_W'(NUM_REGS));
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_out       <= '0;
            r_rd_act    <= 1'b0;
            r_pend      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            for (int i = 0; i < SLOTS; i++) r_regs[i] <= 8'h00;
        end else begin
            r_wr_strobe <= w_commit;
            // A frame start seen during COMMIT is replayed from IDLE next cycle.
            r_pend      <= (r_state == ST_COMMIT) && w_ncs_fall;

            if (w_clear) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (r_state == ST_RX && w_sclk_rise) begin
                r_shift <= w_shift_nxt;
                if (r_cnt != CNT_W'(CNT_SAT)) r_cnt <= r_cnt + 1'b1;
            end

            if (w_commit) begin
                r_wr_addr <= w_addr;
                for (int i = 0; i < SLOTS; i++)
                    if (w_addr == ADDR_W'(i)) r_regs[i] <= r_shift[7:0];
            end

            // The fall right after the load is skipped so bit 7 is stable at the 9th rise.
            if (r_state != ST_RX) begin
                r_rd_act <= 1'b0;
            end else if (w_sclk_rise && r_cnt == CNT_W'(7) && !w_shift_nxt[7]) begin
                r_rd_act <= 1'b1;
                r_out    <= w_rd_data;
            end else if (w_sclk_fall && r_rd_act && r_cnt > CNT_W'(8)) begin
                r_out <= {r_out[6:0], 1'b0};
            end
        end
    end

    assign cipo      = r_rd_act & (r_state == ST_RX) & r_out[7];
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;

    assign reg_en_out                        = r_regs[0];
    assign reg_en_pwm_out                    = r_regs[1];
    assign reg_out_3_0_pwm_gen_channel       = r_regs[2];
    assign reg_out_7_4_pwm_gen_channel       = r_regs[3];
    assign reg_pwm_gen_0_ch_0_duty_cycle     = r_regs[4];
    assign reg_pwm_gen_0_ch_1_duty_cycle     = r_regs[5];
    assign reg_pwm_gen_1_ch_0_duty_cycle     = r_regs[6];
    assign reg_pwm_gen_1_ch_1_duty_cycle     = r_regs[7];
    assign reg_pwm_gen_1_0_frequency_divider = r_regs[8];
endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed SPI frames against a register-file model; outputs compared every clock.
module tb_spi_reg_bank;
    import spi_reg_bank_pkg::*;

    localparam int SS = 2;
    localparam int NR = 9;
    localparam int PH = 4;

    logic clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
    logic       cipo, wr_strobe;
    logic [6:0] wr_addr;
    logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7, r8;

    always #50 clk = ~clk;

    spi_reg_bank #(.SYNC_STAGES(SS), .NUM_REGS(NR)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
        .cipo(cipo), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .reg_en_out(r0), .reg_en_pwm_out(r1),
        .reg_out_3_0_pwm_gen_channel(r2), .reg_out_7_4_pwm_gen_channel(r3),
        .reg_pwm_gen_0_ch_0_duty_cycle(r4), .reg_pwm_gen_0_ch_1_duty_cycle(r5),
        .reg_pwm_gen_1_ch_0_duty_cycle(r6), .reg_pwm_gen_1_ch_1_duty_cycle(r7),
        .reg_pwm_gen_1_0_frequency_divider(r8)
    );

    wire [71:0] w_dut = {r8, r7, r6, r5, r4, r3, r2, r1, r0};

    logic [7:0] m_regs [NR];
    logic [6:0] m_wr_addr = '0;
    int         exp_pulses = 0;
    bit         settled = 1'b1;
    int         checks = 0, passed = 0;
    int         pulses = 0, hi_cycles = 0;
    bit         prev_strobe = 1'b0;
    logic [7:0] rd_got;

    event       ev_commit;
    logic       m_do;
    logic [6:0] m_a;
    logic [7:0] m_d;

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [71:0] m_pack();
        logic [71:0] p;
        for (int i = 0; i < NR; i++) p[i*8 +: 8] = m_regs[i];
        return p;
    endfunction

    // Model applies a frame's effect at the promised visibility deadline after ncs rises.
    initial forever begin
        @(ev_commit);
        settled = 1'b0;
        repeat (SS + 2) @(posedge clk);
        if (m_do) begin
            m_regs[m_a] = m_d;
            m_wr_addr   = m_a;
            exp_pulses++;
        end
        settled = 1'b1;
    end

    initial forever begin
        @(posedge clk);
        #10;
        if (wr_strobe) hi_cycles++;
        if (wr_strobe && !prev_strobe) pulses++;
        prev_strobe = wr_strobe;
        if (settled) begin
            chk("regs", w_dut, m_pack());
            chk("wr_addr", {65'b0, wr_addr}, {65'b0, m_wr_addr});
        end
    end

    task automatic frame(input logic [31:0] w, input int n, input int gap, input int abort_at = -1);
        logic       rw;
        logic [6:0] a;
        logic [7:0] rd;
        logic       ebit;
        rw = w[n-1];
        a  = w[n-2 -: 7];
        rd = (a < NR) ? m_regs[a] : 8'h00;
        rd_got = 8'h00;
        @(negedge clk) ncs = 1'b0;
        repeat (PH) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                rst_n = 1'b0;
                for (int k = 0; k < NR; k++) m_regs[k] = 8'h00;
                m_wr_addr = '0;
                copi = 1'b0; ncs = 1'b1;
                repeat (3) @(negedge clk);
                chk("reset mid-frame", w_dut, 72'h0);
                rst_n = 1'b1;
                repeat (PH) @(negedge clk);
                return;
            end
            copi = w[n-1-i];
            repeat (PH) @(negedge clk);
            ebit = (i >= 8 && i < 16 && !rw) ? rd[15-i] : 1'b0;
            if (i >= 8 && i < 16) rd_got = {rd_got[6:0], cipo};
            chk($sformatf("cipo bit%0d", i), {71'b0, cipo}, {71'b0, ebit});
            sclk = 1'b1;
            repeat (PH) @(negedge clk);
            sclk = 1'b0;
        end
        copi = 1'b0;
        repeat (PH) @(negedge clk);
        ncs  = 1'b1;
        m_do = (n == 16) && rw && (a < NR);
        m_a  = a;
        m_d  = w[7:0];
        -> ev_commit;
        repeat (gap) @(negedge clk);
        chk("cipo idle", {71'b0, cipo}, 72'h0);
    endtask

    initial begin
        for (int k = 0; k < NR; k++) m_regs[k] = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset regs", w_dut, 72'h0);
        chk("reset wr_addr", {65'b0, wr_addr}, 72'h0);
        chk("reset strobe", {71'b0, wr_strobe}, 72'h0);
        chk("reset cipo", {71'b0, cipo}, 72'h0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        frame(32'h80FF, 16, 10);
        chk("en_out ff", {64'b0, r0}, 72'hFF);
        chk("only addr0", w_dut, 72'hFF);
        chk("one strobe", pulses, 1);

        frame({17'b0, 1'b1, ADDR_G0_C0_DUTY, 8'h80}, 16, 10);
        frame(32'h0400, 16, 10);
        chk("read 0x04", {64'b0, rd_got}, 72'h80);
        chk("reg4 kept", {64'b0, r4}, 72'h80);

        frame(32'h8A55, 16, 10);
        chk("oor no strobe", pulses, 2);
        frame(32'h0A00, 16, 10);
        chk("read oor", {64'b0, rd_got}, 72'h00);

        frame(32'h81AA >> 1, 15, 10);
        frame(32'h81AA << 1, 17, 10);
        chk("short/long en_pwm", {64'b0, r1}, 72'h00);
        chk("short/long strobe", pulses, 2);

        @(negedge clk) ncs = 1'b0;
        repeat (3) @(negedge clk);
        ncs = 1'b1;
        for (int k = 0; k < 4; k++) begin
            repeat (PH) @(negedge clk) sclk = 1'b1;
            repeat (PH) @(negedge clk) sclk = 1'b0;
        end
        repeat (8) @(negedge clk);
        chk("glitch strobe", pulses, 2);
        chk("glitch regs", w_dut, 72'h80_0000_00FF);

        frame(32'h8812, 16, 10, 10);
        chk("after reset", w_dut, 72'h0);
        frame({17'b0, 1'b1, ADDR_FREQ_DIV, 8'h21}, 16, 10);
        chk("freq div", {64'b0, r8}, 72'h21);
        chk("only addr8", w_dut, {8'h21, 64'h0});

        frame(32'h82E4, 16, 2);
        frame(32'h831B, 16, 10);
        chk("b2b 02", {64'b0, r2}, 72'hE4);
        chk("b2b 03", {64'b0, r3}, 72'h1B);
        chk("b2b strobes", pulses, 5);

        frame(32'h853C, 16, 0);
        frame(32'h86C3, 16, 10);
        chk("coincide 05", {64'b0, r5}, 72'h3C);
        chk("coincide 06", {64'b0, r6}, 72'hC3);

        repeat (4) @(negedge clk);
        chk("strobe width", hi_cycles, pulses);
        chk("strobe count", pulses, exp_pulses);
        chk("total strobes", pulses, 7);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
